clint_timer: RTL and testbench

//  Memory-mapped machine timer/software-interrupt unit, i.e. the interrupt *source* side of the trap path.

---
 rtl/clint_timer_if.sv | 23 ++
 rtl/clint_timer.sv | 169 ++++++++++++++++
 tb/tb_clint_timer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clint_timer_if.sv
// rtl/clint_timer_if.sv - LSU request/response port of the CLINT timer
interface clint_timer_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_wen_i;
    logic [63:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic [7:0]  req_wstrb_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport master (
        output req_valid_i, req_wen_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_wen_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - CLINT machine timer and software-interrupt source
// Holds mtime/mtimecmp/msip behind a one-outstanding request/response port.
module clint_timer #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic         clk,
    input  logic         rst,
    clint_timer_if.slave bus,
    output logic         mtip_o,
    output logic         msip_o,
    output logic [63:0]  mtime_o
);
    localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
    localparam logic [63:0]   OFF_MSIP  = 64'h0000_0000_0000_0000;
    localparam logic [63:0]   OFF_CMP   = 64'h0000_0000_0000_4000;
    localparam logic [63:0]   OFF_MTIME = 64'h0000_0000_0000_BFF8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_req_ready;
    logic          w_rsp_valid;
    logic          w_accept;

    logic [63:0]   w_offset;
    logic          w_aligned;
    logic          w_sel_msip;
    logic          w_sel_cmp;
    logic          w_sel_mtime;
    logic          w_err;
    logic          w_wr_msip;
    logic          w_wr_cmp;
    logic          w_wr_mtime;
    logic [63:0]   w_rd_mux;
    logic          w_tick;

    logic [63:0]   r_mtime;
    logic [63:0]   r_mtimecmp;
    logic          r_msip;
    logic          r_mtip;
    logic [PW-1:0] r_pre;
    logic [63:0]   r_rsp_rdata;
    logic          r_rsp_err;

    function automatic logic [63:0] f_merge(input logic [63:0] old_v,
                                            input logic [63:0] wdata,
                                            input logic [7:0]  strb);
        logic [63:0] res;
        res = old_v;
        for (int k = 0; k < 8; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = wdata[8*k +: 8];
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid_i) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.req_ready_o = w_req_ready;
    assign bus.rsp_valid_o = w_rsp_valid;
    assign bus.rsp_rdata_o = r_rsp_rdata;
    assign bus.rsp_err_o   = r_rsp_err;
    assign w_accept        = w_req_ready & bus.req_valid_i;

    // Decode on the full 64-bit offset so aliases outside the window fault.
    assign w_offset    = bus.req_addr_i - BASE_ADDR;
    assign w_aligned   = (bus.req_addr_i[2:0] == 3'b000);
    assign w_sel_msip  = w_aligned && (w_offset == OFF_MSIP);
    assign w_sel_cmp   = w_aligned && (w_offset == OFF_CMP);
    assign w_sel_mtime = w_aligned && (w_offset == OFF_MTIME);
    assign w_err       = !(w_sel_msip || w_sel_cmp || w_sel_mtime);

    assign w_wr_msip  = w_accept && bus.req_wen_i && w_sel_msip;
    assign w_wr_cmp   = w_accept && bus.req_wen_i && w_sel_cmp;
    assign w_wr_mtime = w_accept && bus.req_wen_i && w_sel_mtime;

    always_comb begin
        w_rd_mux = '0;
        if (w_sel_msip) begin
            w_rd_mux = {63'b0, r_msip};
        end else if (w_sel_cmp) begin
            w_rd_mux = r_mtimecmp;
        end else if (w_sel_mtime) begin
            w_rd_mux = r_mtime;
        end
    end

    assign w_tick = (r_pre == PRE_MAX);

    // A software write to mtime overrides the tick and restarts the prescaler.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre   <= '0;
            r_mtime <= '0;
        end else if (w_wr_mtime) begin
            r_pre   <= '0;
            r_mtime <= f_merge(r_mtime, bus.req_wdata_i, bus.req_wstrb_i);
        end else if (w_tick) begin
            r_pre   <= '0;
            r_mtime <= r_mtime + 64'd1;
        end else begin
            r_pre   <= r_pre + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mtimecmp <= '1;
            r_msip     <= 1'b0;
            r_mtip     <= 1'b0;
        end else begin
            if (w_wr_cmp) begin
                r_mtimecmp <= f_merge(r_mtimecmp, bus.req_wdata_i, bus.req_wstrb_i);
            end
            if (w_wr_msip && bus.req_wstrb_i[0]) begin
                r_msip <= bus.req_wdata_i[0];
            end
            r_mtip <= (r_mtime >= r_mtimecmp);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_err   <= w_err;
            r_rsp_rdata <= bus.req_wen_i ? 64'd0 : w_rd_mux;
        end
    end

    assign mtip_o  = r_mtip;
    assign msip_o  = r_msip;
    assign mtime_o = r_mtime;
endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - self-checking bench for clint_timer (TICK_DIV 1 and 4 side by side)
module tb_clint_timer;
    localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    clint_timer_if bus1 ();
    clint_timer_if bus4 ();

    logic        mtip1, mtip4, msip1, msip4;
    logic [63:0] mtime1, mtime4;

    clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .mtip_o(mtip1), .msip_o(msip1), .mtime_o(mtime1));
    clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .mtip_o(mtip4), .msip_o(msip4), .mtime_o(mtime4));

    logic [63:0] mtime_a [2];
    logic [63:0] rdata_a [2];
    logic        mtip_a [2];
    logic        msip_a [2];
    logic        rvalid_a [2];
    logic        ready_a [2];
    logic        err_a [2];
    assign mtime_a[0] = mtime1;            assign mtime_a[1] = mtime4;
    assign mtip_a[0]  = mtip1;             assign mtip_a[1]  = mtip4;
    assign msip_a[0]  = msip1;             assign msip_a[1]  = msip4;
    assign rdata_a[0] = bus1.rsp_rdata_o;  assign rdata_a[1] = bus4.rsp_rdata_o;
    assign rvalid_a[0] = bus1.rsp_valid_o; assign rvalid_a[1] = bus4.rsp_valid_o;
    assign ready_a[0] = bus1.req_ready_o;  assign ready_a[1] = bus4.req_ready_o;
    assign err_a[0]   = bus1.rsp_err_o;    assign err_a[1]   = bus4.rsp_err_o;

    longint edge_n;
    always @(posedge clk or negedge rst) begin
        if (!rst) edge_n <= 0;
        else      edge_n <= edge_n + 1;
    end

    int checks = 0;
    int failures = 0;

    // Reference: mtime after edge k = base + floor((k - base_edge) / div), one write of history kept.
    logic [63:0] m_W [2];
    logic [63:0] m_W_old [2];
    longint      m_w [2];
    longint      m_w_old [2];
    logic [63:0] m_cmp, m_cmp_old;
    longint      m_cmp_e;
    logic        m_msip;

    function automatic longint div_of(input int d);
        return (d == 0) ? 64'sd1 : 64'sd4;
    endfunction

    function automatic logic [63:0] mt(input int d, input longint k);
        if (k >= m_w[d]) return m_W[d] + 64'((k - m_w[d]) / div_of(d));
        return m_W_old[d] + 64'((k - m_w_old[d]) / div_of(d));
    endfunction

    function automatic logic [63:0] cmp_at(input longint k);
        return (k >= m_cmp_e) ? m_cmp : m_cmp_old;
    endfunction

    function automatic logic exp_mtip(input int d, input longint e);
        if (e == 0) return 1'b0;
        return mt(d, e - 1) >= cmp_at(e - 1);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] s);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = s[k] ? n[8*k +: 8] : o[8*k +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_W[d] = 0; m_W_old[d] = 0; m_w[d] = 0; m_w_old[d] = 0;
        end
        m_cmp = ONES; m_cmp_old = ONES; m_cmp_e = 0; m_msip = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] strb, input bit rr);
        bus1.req_valid_i = v;  bus4.req_valid_i = v;
        bus1.req_wen_i = wen;  bus4.req_wen_i = wen;
        bus1.req_addr_i = addr; bus4.req_addr_i = addr;
        bus1.req_wdata_i = wdata; bus4.req_wdata_i = wdata;
        bus1.req_wstrb_i = strb; bus4.req_wstrb_i = strb;
        bus1.rsp_ready_i = rr; bus4.rsp_ready_i = rr;
    endtask

    task automatic check_state();
        longint e;
        e = edge_n;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("mtime_d%0d", d), mtime_a[d], mt(d, e));
            chk($sformatf("mtip_d%0d", d), 64'(mtip_a[d]), 64'(exp_mtip(d, e)));
            chk($sformatf("msip_d%0d", d), 64'(msip_a[d]), 64'(m_msip));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check_state();
        end
    endtask

    task automatic txn(input bit wen, input logic [63:0] off, input logic [63:0] wdata,
                       input logic [7:0] strb, input int hold, input bit junk,
                       output logic [63:0] rd, output bit er, output longint acc_e);
        logic [63:0] exp_rd [2];
        logic [63:0] nv;
        bit          exp_er;
        longint      e;
        for (int d = 0; d < 2; d++) chk("req_ready_idle", 64'(ready_a[d]), 64'd1);
        drive(1'b1, wen, BASE + off, wdata, strb, 1'b0);
        @(negedge clk);
        e = edge_n;
        acc_e = e;
        exp_er = !(off == 64'h0 || off == 64'h4000 || off == 64'hBFF8);
        for (int d = 0; d < 2; d++) begin
            exp_rd[d] = 64'd0;
            if (!exp_er && !wen) begin
                if (off == 64'h0)         exp_rd[d] = 64'(m_msip);
                else if (off == 64'h4000) exp_rd[d] = m_cmp;
                else                      exp_rd[d] = mt(d, e - 1);
            end
        end
        if (!exp_er && wen) begin
            if (off == 64'h0) begin
                if (strb[0]) m_msip = wdata[0];
            end else if (off == 64'h4000) begin
                m_cmp_old = m_cmp;
                m_cmp = merge(m_cmp, wdata, strb);
                m_cmp_e = e;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    nv = merge(mt(d, e - 1), wdata, strb);
                    m_W_old[d] = m_W[d]; m_w_old[d] = m_w[d];
                    m_W[d] = nv; m_w[d] = e;
                end
            end
        end
        drive(1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b0);
        check_state();
        for (int d = 0; d < 2; d++) begin
            chk("rsp_valid", 64'(rvalid_a[d]), 64'd1);
            chk("rsp_rdata", rdata_a[d], exp_rd[d]);
            chk("rsp_err", 64'(err_a[d]), 64'(exp_er));
        end
        rd = rdata_a[0];
        er = err_a[0];
        for (int h = 0; h < hold; h++) begin
            if (junk) drive(1'b1, 1'b1, BASE, 64'(~m_msip), 8'hFF, 1'b0);
            @(negedge clk);
            check_state();
            for (int d = 0; d < 2; d++) begin
                chk("hold_valid", 64'(rvalid_a[d]), 64'd1);
                chk("hold_ready", 64'(ready_a[d]), 64'd0);
                chk("hold_rdata", rdata_a[d], exp_rd[d]);
                chk("hold_err", 64'(err_a[d]), 64'(exp_er));
            end
        end
        drive(1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b1);
        @(negedge clk);
        check_state();
        for (int d = 0; d < 2; d++) begin
            chk("rsp_done_valid", 64'(rvalid_a[d]), 64'd0);
            chk("rsp_done_ready", 64'(ready_a[d]), 64'd1);
        end
        drive(1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b0);
    endtask

    typedef struct {
        bit          wen;
        logic [63:0] off;
        logic [63:0] wdata;
        logic [7:0]  strb;
        logic [63:0] exp_rd;
        bit          exp_err;
        string       nm;
    } vec_t;

    initial begin
        vec_t        tbl[$];
        logic [63:0] rd, off;
        bit          er;
        longint      w, rise1, rise4;

        model_reset();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b0);
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_rsp_valid", 64'(rvalid_a[d]), 64'd0);
            chk("rst_rdata", rdata_a[d], 64'd0);
            chk("rst_err", 64'(err_a[d]), 64'd0);
            chk("rst_mtip", 64'(mtip_a[d]), 64'd0);
            chk("rst_msip", 64'(msip_a[d]), 64'd0);
            chk("rst_mtime", mtime_a[d], 64'd0);
            chk("rst_ready", 64'(ready_a[d]), 64'd1);
        end
        #1 rst = 1'b1;

        idle(3);
        chk("count_d1", mtime_a[0], 64'd3);
        chk("count_d4", mtime_a[1], 64'd0);
        txn(1'b0, 64'hBFF8, 64'd0, 8'h00, 0, 1'b0, rd, er, w);
        chk("read_mtime_T", rd, 64'(w - 1));

        txn(1'b1, 64'h4000, 64'd10, 8'hFF, 0, 1'b0, rd, er, w);
        txn(1'b1, 64'hBFF8, 64'd0, 8'hFF, 0, 1'b0, rd, er, w);
        rise1 = -1; rise4 = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_state();
            if (rise1 < 0 && mtip_a[0]) rise1 = edge_n;
            if (rise4 < 0 && mtip_a[1]) rise4 = edge_n;
        end
        chk("mtip_rise_d1", 64'(rise1), 64'(w + 11));
        chk("mtip_rise_d4", 64'(rise4), 64'(w + 41));
        chk("mtip_stays_d1", 64'(mtip_a[0]), 64'd1);
        txn(1'b1, 64'h4000, ONES, 8'hFF, 0, 1'b0, rd, er, w);
        chk("mtip_clear_d1", 64'(mtip_a[0]), 64'd0);

        txn(1'b1, 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, 1'b0, rd, er, w);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_state();
            if (edge_n == w + 2) chk("wrap_d1", mtime_a[0], 64'd0);
            if (edge_n == w + 3) chk("pre_restart_d4", mtime_a[1], 64'hFFFF_FFFF_FFFF_FFFE);
            if (edge_n == w + 4) chk("tick4_d4", mtime_a[1], ONES);
            if (edge_n == w + 8) chk("wrap_d4", mtime_a[1], 64'd0);
        end

        txn(1'b1, 64'h4004, ONES, 8'hFF, 3, 1'b1, rd, er, w);
        chk("err_4004", 64'(er), 64'd1);
        chk("err_4004_rd", rd, 64'd0);
        txn(1'b0, 64'h1000, 64'd0, 8'h00, 3, 1'b1, rd, er, w);
        chk("err_1000", 64'(er), 64'd1);
        chk("err_1000_rd", rd, 64'd0);

        tbl.push_back('{1'b1, 64'h0,    64'h3,                  8'hFF, 64'h0,                  1'b0, "w_msip3"});
        tbl.push_back('{1'b0, 64'h0,    64'h0,                  8'h00, 64'h1,                  1'b0, "r_msip1"});
        tbl.push_back('{1'b1, 64'h0,    64'h0,                  8'hFF, 64'h0,                  1'b0, "w_msip0"});
        tbl.push_back('{1'b0, 64'h0,    64'h0,                  8'h00, 64'h0,                  1'b0, "r_msip0"});
        tbl.push_back('{1'b1, 64'h0,    64'h1,                  8'hFF, 64'h0,                  1'b0, "w_msip1"});
        tbl.push_back('{1'b1, 64'h0,    64'h0,                  8'h00, 64'h0,                  1'b0, "w_msip_nostrb"});
        tbl.push_back('{1'b0, 64'h0,    64'h0,                  8'h00, 64'h1,                  1'b0, "r_msip_kept"});
        tbl.push_back('{1'b1, 64'h4004, 64'hFFFF,               8'hFF, 64'h0,                  1'b1, "w_misalign"});
        tbl.push_back('{1'b0, 64'h1000, 64'h0,                  8'h00, 64'h0,                  1'b1, "r_unmapped"});
        tbl.push_back('{1'b0, 64'h8,    64'h0,                  8'h00, 64'h0,                  1'b1, "r_off8"});
        tbl.push_back('{1'b1, 64'h4000, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0,                 1'b0, "w_cmp"});
        tbl.push_back('{1'b0, 64'h4000, 64'h0,                  8'h00, 64'h0123_4567_89AB_CDEF, 1'b0, "r_cmp"});
        tbl.push_back('{1'b1, 64'h4000, 64'h0,                  8'h0F, 64'h0,                  1'b0, "w_cmp_lo"});
        tbl.push_back('{1'b0, 64'h4000, 64'h0,                  8'h00, 64'h0123_4567_0000_0000, 1'b0, "r_cmp_lo"});
        tbl.push_back('{1'b1, 64'h4000, ONES,                   8'hFF, 64'h0,                  1'b0, "w_cmp_ones"});
        tbl.push_back('{1'b0, 64'h4000, 64'h0,                  8'h00, ONES,                   1'b0, "r_cmp_ones"});
        for (int i = 0; i < tbl.size(); i++) begin
            txn(tbl[i].wen, tbl[i].off, tbl[i].wdata, tbl[i].strb, i % 3, 1'b1, rd, er, w);
            chk({tbl[i].nm, "_rd"}, rd, tbl[i].exp_rd);
            chk({tbl[i].nm, "_err"}, 64'(er), 64'(tbl[i].exp_err));
        end

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 4))
                0: off = 64'h0;
                1: off = 64'h4000;
                2: off = 64'hBFF8;
                3: off = 64'($urandom_range(0, 16'hFFFF));
                default: off = {$urandom, $urandom};
            endcase
            txn(1'($urandom), off, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 2),
                1'($urandom), rd, er, w);
            idle($urandom_range(0, 2));
        end

        drive(1'b1, 1'b1, BASE + 64'hBFF8, 64'h1234, 8'hFF, 1'b0);
        @(negedge clk);
        chk("mid_rsp_valid", 64'(rvalid_a[0]), 64'd1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk("arst_rsp_valid", 64'(rvalid_a[d]), 64'd0);
            chk("arst_ready", 64'(ready_a[d]), 64'd1);
            chk("arst_mtime", mtime_a[d], 64'd0);
            chk("arst_rdata", rdata_a[d], 64'd0);
        end
        @(negedge clk);
        #1 rst = 1'b1;
        idle(2);
        txn(1'b0, 64'h4000, 64'd0, 8'h00, 0, 1'b0, rd, er, w);
        chk("post_rst_cmp", rd, ONES);
        txn(1'b0, 64'hBFF8, 64'd0, 8'h00, 1, 1'b0, rd, er, w);
        chk("post_rst_mtime", rd, 64'(w - 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
